// File: rtl/arb_mux_pkg.sv
// Shared types for the arbitrated, registered N-way select mux.
// Holds the grant FSM encoding and the packed-bus slice helper.
package arb_mux_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Combinational arbiter: the lowest requester wins, or the first requester found from rr_ptr upward with wrap.
// No latency and no state; the caller owns the pointer and any backpressure.
module rr_arbiter #(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0]         req,
  input  logic [$clog2(N_IN)-1:0] rr_ptr,
  input  logic                    mode_rr,
  output logic [N_IN-1:0]         gnt,
  output logic [$clog2(N_IN)-1:0] gnt_idx
);

  localparam int SELW = $clog2(N_IN);

  // Fixed priority is the same scan starting from channel 0.
  always_comb begin
    int   base;
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    base    = mode_rr ? int'(rr_ptr) : 0;
    for (int i = 0; i < N_IN; i++) begin
      idx = (base + i) % N_IN;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/arb_mux_reg.sv
// N-way valid/ready mux into one registered output stage. Input-to-output latency is 1 cycle.
// Under backpressure the held word stays stable and every in_ready is low. A packet without in_last locks the grant to its channel.
module arb_mux_reg
  import arb_mux_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mode_rr,
  input  logic                    force_en,
  input  logic [$clog2(N_IN)-1:0] force_sel,
  input  logic [N_IN-1:0]         in_valid,
  input  logic [N_IN-1:0]         in_last,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  output logic [N_IN-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [$clog2(N_IN)-1:0] out_sel,
  output logic                    out_last,
  input  logic                    out_ready
);

  localparam int              SELW    = $clog2(N_IN);
  localparam logic [SELW:0]   NIN_W   = (SELW+1)'(N_IN);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N_IN - 1);
  localparam logic [N_IN-1:0] ONE     = N_IN'(1);

  state_t          state;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] lock_ch;

  logic [N_IN-1:0]  arb_gnt;
  logic [SELW-1:0]  arb_idx;
  logic [N_IN-1:0]  cand_oh;
  logic [SELW-1:0]  cand_idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic [SELW-1:0]  ptr_next;
  logic             load_en;
  logic             xfer;

  rr_arbiter #(
    .N_IN (N_IN)
  ) u_arb (
    .req     (in_valid),
    .rr_ptr  (rr_ptr),
    .mode_rr (mode_rr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // A lock outranks a forced select, and a forced select outranks the arbiter.
  always_comb begin
    cand_oh  = '0;
    cand_idx = '0;
    if (state == LOCKED) begin
      cand_oh  = ONE << lock_ch;
      cand_idx = lock_ch;
    end else if (force_en) begin
      if ({1'b0, force_sel} < NIN_W) begin
        cand_oh  = ONE << force_sel;
        cand_idx = force_sel;
      end
    end else begin
      cand_oh  = arb_gnt;
      cand_idx = arb_idx;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (cand_oh[k]) begin
        sel_data = in_data[slice_lo(k, WIDTH) +: WIDTH];
        sel_last = in_last[k];
      end
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = (reset_n && load_en) ? (cand_oh & in_valid) : '0;
  assign xfer     = |in_ready;
  assign ptr_next = (cand_idx == LAST_CH) ? '0 : cand_idx + SELW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      rr_ptr    <= '0;
      lock_ch   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= cand_idx;
        out_last  <= sel_last;
        if (sel_last) begin
          rr_ptr <= ptr_next;
        end
        case (state)
          ARB: begin
            if (!sel_last) begin
              state   <= LOCKED;
              lock_ch <= cand_idx;
            end
          end
          LOCKED: begin
            if (sel_last) begin
              state <= ARB;
            end
          end
          default: state <= ARB;
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Scoreboard bench for arb_mux_reg: packet-level model predicts grants and words, monitor checks drained words.
module tb_arb_mux_reg;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           mode_rr;
  logic           force_en;
  logic [1:0]     force_sel;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_last;
  logic           out_ready;

  always #5 clk = ~clk;

  arb_mux_reg #(.N_IN(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode_rr   (mode_rr),
    .force_en  (force_en),
    .force_sel (force_sel),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [1:0]   sel;
    logic         last;
    logic [W-1:0] data;
  } word_t;

  word_t expq[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Model state: channel owning an unfinished packet (-1 none), channel after the
  // last completed packet, and whether the output stage holds a word.
  int    m_lock = -1;
  int    m_rr   = 0;
  bit    m_occ  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_checks++;
        $display("FAIL out_word: DUT drained %0h but no word was expected", {out_sel, out_last, out_data});
      end else begin
        word_t w;
        w = expq.pop_front();
        check("out_word", {out_sel, out_last, out_data}, w);
      end
    end
  end

  task automatic model_cycle();
    int           c;
    logic [N-1:0] er;
    bit           load;
    c    = -1;
    load = !m_occ || out_ready;
    check("out_valid", out_valid, m_occ);
    if (m_lock >= 0) begin
      c = m_lock;
    end else if (force_en) begin
      if (int'(force_sel) < N) c = int'(force_sel);
    end else begin
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = mode_rr ? (m_rr + i) % N : i;
        if (c < 0 && in_valid[idx]) c = idx;
      end
    end
    if (c >= 0 && !in_valid[c]) c = -1;
    if (!load) c = -1;
    er = '0;
    if (c >= 0) er[c] = 1'b1;
    check("in_ready", in_ready, er);
    if (c >= 0) begin
      word_t w;
      w.sel  = c[1:0];
      w.last = in_last[c];
      w.data = in_data[c*W +: W];
      expq.push_back(w);
      m_occ = 1'b1;
      if (!in_last[c]) m_lock = c;
      else begin
        m_lock = -1;
        m_rr   = (c + 1) % N;
      end
    end else if (out_ready) begin
      m_occ = 1'b0;
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy,
                      input logic rr, input logic fe, input logic [1:0] fs);
    in_valid  = v;
    in_last   = l;
    out_ready = rdy;
    mode_rr   = rr;
    force_en  = fe;
    force_sel = fs;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_sel"},   out_sel,   0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_in_ready"},  in_ready,  0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = '0;
    out_ready = 1'b1;
    mode_rr   = 1'b0;
    force_en  = 1'b0;
    force_sel = 2'd0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Fixed priority with everyone valid: channel 0 every cycle.
    repeat (4) step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0);
    // Round-robin with everyone valid: rotation with wrap.
    repeat (6) step(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0);
    // Backpressure for three cycles, then release.
    repeat (3) step(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (2) step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0);

    // Channel 2 packet of three beats with a gap while channel 0 stays valid.
    step(4'b0101, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd2);
    step(4'b0101, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0);
    step(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0);
    step(4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0, 2'd0);
    step(4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0, 2'd0);

    // Forced select on an idle channel, then that channel arrives.
    repeat (2) step(4'b0111, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd3);
    repeat (2) step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd3);
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0);

    // Randomised traffic with all controls varying.
    begin
      logic rr_mode;
      rr_mode = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 49) == 0) rr_mode = ~rr_mode;
        step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             logic'($urandom_range(0, 3) != 0), rr_mode,
             logic'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)));
      end
    end
    repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0);
    check("queue_empty", expq.size(), 0);

    // Reset while locked and holding a stalled word.
    step(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2);
    step(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    expq.delete();
    m_lock = -1;
    m_rr   = 0;
    m_occ  = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0);
    repeat (2) step(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0);
    check("final_queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
